// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter and bus mux sharing one single-port memory among three clients,
// with an optional hold limit that revokes a grant while other clients are waiting.
module mem_rr_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        requestingMemory,
  output logic [2:0]        grantedAccess,
  output logic [2:0]        preempted,
  output logic              enabled,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dataToMem,
  output logic              readWrite,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  input  logic [DATA_W-1:0] dataToMem1,
  input  logic [DATA_W-1:0] dataToMem2,
  input  logic [DATA_W-1:0] dataToMem3,
  input  logic              readWrite1,
  input  logic              readWrite2,
  input  logic              readWrite3
);

  localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      grant_q, grant_d;
  logic [2:0]      pre_q, pre_d;
  logic [2:0]      last_q, last_d;
  logic [HC_W-1:0] hold_q, hold_d;
  logic [2:0]      winner_s;
  logic            holder_req_s;
  logic            others_wait_s;
  logic            limit_hit_s;

  // Circular priority search starting at the bit after the last grant.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [2:0] last);
    logic [2:0] pick;
    pick = 3'b000;
    case (last)
      3'b001: begin
        if      (req[1]) pick = 3'b010;
        else if (req[2]) pick = 3'b100;
        else if (req[0]) pick = 3'b001;
        else             pick = 3'b000;
      end
      3'b010: begin
        if      (req[2]) pick = 3'b100;
        else if (req[0]) pick = 3'b001;
        else if (req[1]) pick = 3'b010;
        else             pick = 3'b000;
      end
      default: begin
        if      (req[0]) pick = 3'b001;
        else if (req[1]) pick = 3'b010;
        else if (req[2]) pick = 3'b100;
        else             pick = 3'b000;
      end
    endcase
    return pick;
  endfunction

  assign winner_s      = rr_pick(requestingMemory, last_q);
  assign holder_req_s  = |(requestingMemory & grant_q);
  assign others_wait_s = |(requestingMemory & ~grant_q);
  assign limit_hit_s   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  // Next-state logic; release is checked before preemption so a same-edge drop is never flagged.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    pre_d   = 3'b000;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (|requestingMemory) begin
          grant_d = winner_s;
          hold_d  = '0;
          state_d = S_GRANT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (!holder_req_s) begin
          grant_d = 3'b000;
          last_d  = grant_q;
          state_d = S_GAP;
        end else if (limit_hit_s && others_wait_s) begin
          grant_d = 3'b000;
          pre_d   = grant_q;
          last_d  = grant_q;
          state_d = S_GAP;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end else begin
          hold_d = hold_q;
        end
      end
      S_GAP: begin
        if (|requestingMemory) begin
          grant_d = winner_s;
          hold_d  = '0;
          state_d = S_GRANT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        grant_d = 3'b000;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= 3'b000;
      pre_q   <= 3'b000;
      last_q  <= 3'b100;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      pre_q   <= pre_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign grantedAccess = grant_q;
  assign preempted     = pre_q;
  assign enabled       = |grant_q;

  // Bus mux driven from the registered grant; idle bus is all zeros.
  always_comb begin
    address   = '0;
    dataToMem = '0;
    readWrite = 1'b0;
    case (grant_q)
      3'b001: begin
        address   = addr1;
        dataToMem = dataToMem1;
        readWrite = readWrite1;
      end
      3'b010: begin
        address   = addr2;
        dataToMem = dataToMem2;
        readWrite = readWrite2;
      end
      3'b100: begin
        address   = addr3;
        dataToMem = dataToMem3;
        readWrite = readWrite3;
      end
      default: begin
        address   = '0;
        dataToMem = '0;
        readWrite = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: three instances (MAX_HOLD 16, 0, 4) share stimulus,
// a vector table drives per-cycle requests and a scoreboard queue holds expected outputs.
module tb_mem_rr_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    req = 3'b000;
  logic [AW-1:0] addr1 = 8'h2A, addr2 = 8'h55, addr3 = 8'hC3;
  logic [DW-1:0] dat1 = 32'h1111_1111, dat2 = 32'h2222_2222, dat3 = 32'h3333_3333;
  logic          rw1 = 1'b1, rw2 = 1'b0, rw3 = 1'b1;

  logic [2:0]    g [3];
  logic [2:0]    p [3];
  logic          e [3];
  logic [AW-1:0] a [3];
  logic [DW-1:0] d [3];
  logic          rw [3];

  int sel = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(16)) u_h16 (
    .clk(clk), .rst(rst), .requestingMemory(req),
    .grantedAccess(g[0]), .preempted(p[0]), .enabled(e[0]),
    .address(a[0]), .dataToMem(d[0]), .readWrite(rw[0]),
    .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .dataToMem1(dat1), .dataToMem2(dat2), .dataToMem3(dat3),
    .readWrite1(rw1), .readWrite2(rw2), .readWrite3(rw3));

  mem_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(0)) u_h0 (
    .clk(clk), .rst(rst), .requestingMemory(req),
    .grantedAccess(g[1]), .preempted(p[1]), .enabled(e[1]),
    .address(a[1]), .dataToMem(d[1]), .readWrite(rw[1]),
    .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .dataToMem1(dat1), .dataToMem2(dat2), .dataToMem3(dat3),
    .readWrite1(rw1), .readWrite2(rw2), .readWrite3(rw3));

  mem_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(4)) u_h4 (
    .clk(clk), .rst(rst), .requestingMemory(req),
    .grantedAccess(g[2]), .preempted(p[2]), .enabled(e[2]),
    .address(a[2]), .dataToMem(d[2]), .readWrite(rw[2]),
    .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .dataToMem1(dat1), .dataToMem2(dat2), .dataToMem3(dat3),
    .readWrite1(rw1), .readWrite2(rw2), .readWrite3(rw3));

  typedef struct packed {
    logic [1:0] sel;
    logic       rs;
    logic [2:0] req;
    logic [2:0] grant;
    logic [2:0] pre;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic void add(input int s, input bit rs, input logic [2:0] r,
                              input logic [2:0] gg, input logic [2:0] pp);
    vec_t v;
    v.sel   = 2'(s);
    v.rs    = rs;
    v.req   = r;
    v.grant = gg;
    v.pre   = pp;
    tbl.push_back(v);
  endfunction

  function automatic logic [AW-1:0] exp_addr(input logic [2:0] gr);
    case (gr)
      3'b001:  return addr1;
      3'b010:  return addr2;
      3'b100:  return addr3;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [2:0] gr);
    case (gr)
      3'b001:  return dat1;
      3'b010:  return dat2;
      3'b100:  return dat3;
      default: return '0;
    endcase
  endfunction

  function automatic logic exp_rw(input logic [2:0] gr);
    case (gr)
      3'b001:  return rw1;
      3'b010:  return rw2;
      3'b100:  return rw3;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] eg, input logic [2:0] ep);
    check({tag, ".grant"},     32'(g[sel]),  32'(eg));
    check({tag, ".preempted"}, 32'(p[sel]),  32'(ep));
    check({tag, ".enabled"},   32'(e[sel]),  32'(|eg));
    check({tag, ".address"},   32'(a[sel]),  32'(exp_addr(eg)));
    check({tag, ".dataToMem"}, 32'(d[sel]),  32'(exp_data(eg)));
    check({tag, ".readWrite"}, 32'(rw[sel]), 32'(exp_rw(eg)));
  endtask

  task automatic step(input vec_t v, input string tag);
    vec_t x;
    req = v.req;
    sb.push_back(v);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check_outputs(tag, x.grant, x.pre);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 3'b000;
    #1;
    check_outputs("reset", 3'b000, 3'b000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t v;
    // Single lone requester on MAX_HOLD=16: never preempted.
    add(0, 1'b1, 3'b001, 3'b001, 3'b000);
    repeat (19) add(0, 1'b0, 3'b001, 3'b001, 3'b000);
    repeat (2)  add(0, 1'b0, 3'b000, 3'b000, 3'b000);
    // All three request, MAX_HOLD=0: 001, 010, 100 with one dead cycle between.
    add(1, 1'b1, 3'b111, 3'b001, 3'b000);
    repeat (4) add(1, 1'b0, 3'b111, 3'b001, 3'b000);
    add(1, 1'b0, 3'b110, 3'b000, 3'b000);
    repeat (5) add(1, 1'b0, 3'b110, 3'b010, 3'b000);
    add(1, 1'b0, 3'b100, 3'b000, 3'b000);
    repeat (5) add(1, 1'b0, 3'b100, 3'b100, 3'b000);
    repeat (2) add(1, 1'b0, 3'b000, 3'b000, 3'b000);
    // Rotation: after module 2 releases, 3 beats 1.
    add(1, 1'b1, 3'b010, 3'b010, 3'b000);
    add(1, 1'b0, 3'b010, 3'b010, 3'b000);
    add(1, 1'b0, 3'b101, 3'b000, 3'b000);
    repeat (2) add(1, 1'b0, 3'b101, 3'b100, 3'b000);
    add(1, 1'b0, 3'b001, 3'b000, 3'b000);
    add(1, 1'b0, 3'b001, 3'b001, 3'b000);
    repeat (2) add(1, 1'b0, 3'b000, 3'b000, 3'b000);
    // Preemption at MAX_HOLD=4, then module 2, then module 1 again.
    add(2, 1'b1, 3'b001, 3'b001, 3'b000);
    repeat (3) add(2, 1'b0, 3'b011, 3'b001, 3'b000);
    add(2, 1'b0, 3'b011, 3'b000, 3'b001);
    repeat (2) add(2, 1'b0, 3'b011, 3'b010, 3'b000);
    add(2, 1'b0, 3'b001, 3'b000, 3'b000);
    add(2, 1'b0, 3'b001, 3'b001, 3'b000);
    repeat (2) add(2, 1'b0, 3'b000, 3'b000, 3'b000);
    // Holder drops on the limit edge: a release, not a preemption.
    add(2, 1'b1, 3'b001, 3'b001, 3'b000);
    repeat (3) add(2, 1'b0, 3'b011, 3'b001, 3'b000);
    add(2, 1'b0, 3'b010, 3'b000, 3'b000);
    add(2, 1'b0, 3'b010, 3'b010, 3'b000);
    repeat (2) add(2, 1'b0, 3'b000, 3'b000, 3'b000);
    // Lone holder past the limit, then a newcomer forces preemption at once.
    add(2, 1'b1, 3'b001, 3'b001, 3'b000);
    repeat (9) add(2, 1'b0, 3'b001, 3'b001, 3'b000);
    add(2, 1'b0, 3'b011, 3'b000, 3'b001);
    add(2, 1'b0, 3'b011, 3'b010, 3'b000);
    repeat (2) add(2, 1'b0, 3'b000, 3'b000, 3'b000);

    #1;
    check_outputs("por", 3'b000, 3'b000);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      sel = int'(v.sel);
      if (v.rs) do_reset();
      step(v, $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a grant to module 2.
    sel = 1;
    do_reset();
    v = '0;
    v.sel = 2'd1; v.req = 3'b010; v.grant = 3'b010; v.pre = 3'b000;
    step(v, "mid_pre");
    #2;
    rst = 1'b1;
    #1;
    check_outputs("mid_rst", 3'b000, 3'b000);
    req = 3'b111;
    @(negedge clk);
    rst = 1'b0;
    v.req = 3'b111; v.grant = 3'b001;
    step(v, "post_rst");
    step(v, "post_rst_hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
